// File: rtl/switch_button_peripheral.sv
// Basys3 board-input peripheral: synchronises and debounces 16 switches and 5 buttons,
// latches button presses for a level interrupt, and serves everything on an 8-bit read port.
module switch_button_peripheral #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  input  logic [4:0]  btn,
  input  logic        read_enable,
  input  logic [7:0]  read_address,
  output logic [7:0]  read_data,
  output logic        read_valid,
  output logic        btn_irq
);

  localparam int N = 21;
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] ID = 8'hB3;

  logic [N-1:0]  raw;
  logic [N-1:0]  s1;
  logic [N-1:0]  s2;
  logic [N-1:0]  stable;
  logic [N-1:0]  stable_next;
  logic [CW-1:0] cnt      [N];
  logic [CW-1:0] cnt_next [N];
  logic [4:0]    press_latch;
  logic [4:0]    latch_next;
  logic [4:0]    rise;
  logic [7:0]    read_mux;

  // Buttons occupy the top five bits so one debounce loop covers every input.
  assign raw = {btn, sw};

  // Any cycle of agreement restarts the count, so only a full run of disagreement flips a bit.
  always_comb begin
    stable_next = stable;
    for (int i = 0; i < N; i++) begin
      cnt_next[i] = '0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] == LAST) begin
          stable_next[i] = s2[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    read_mux = 8'h00;
    case (read_address)
      8'h00:   read_mux = stable[7:0];
      8'h01:   read_mux = stable[15:8];
      8'h02:   read_mux = {3'b000, stable[20:16]};
      8'h03:   read_mux = {3'b000, press_latch};
      8'h04:   read_mux = ID;
      default: read_mux = 8'h00;
    endcase
  end

  // A press arriving on the clearing edge is OR-ed in after the clear, so set wins.
  assign rise = stable_next[20:16] & ~stable[20:16];

  always_comb begin
    latch_next = press_latch;
    if (read_enable && (read_address == 8'h03)) begin
      latch_next = '0;
    end
    latch_next = latch_next | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      stable      <= '0;
      press_latch <= '0;
      read_data   <= '0;
      read_valid  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1          <= raw;
      s2          <= s1;
      stable      <= stable_next;
      press_latch <= latch_next;
      read_valid  <= read_enable;
      if (read_enable) begin
        read_data <= read_mux;
      end
      for (int i = 0; i < N; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign btn_irq = |press_latch;

endmodule

// File: tb/tb_switch_button_peripheral.sv
// Bench for switch_button_peripheral: directed read tables and corner sequences, then
// random input/read traffic compared every cycle against a sliding-window reference model.
module tb_switch_button_peripheral;

  localparam int D = 4;

  logic        clk;
  logic        rst;
  logic [15:0] sw;
  logic [4:0]  btn;
  logic        read_enable;
  logic [7:0]  read_address;
  logic [7:0]  read_data;
  logic        read_valid;
  logic        btn_irq;

  int tests_run;
  int tests_failed;
  bit check_en;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp_data;
    logic       exp_irq;
  } vec_t;

  vec_t vecs [9];

  // Reference model: a bit flips once the last D synchronised samples all disagree with it.
  logic [20:0] hist [0:D];
  logic [20:0] m_stable;
  logic [4:0]  m_latch;
  logic [7:0]  m_rdata;
  logic        m_rvalid;

  switch_button_peripheral #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .btn          (btn),
    .read_enable  (read_enable),
    .read_address (read_address),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .btn_irq      (btn_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_step();
    logic [20:0] nxt;
    logic [4:0]  rise;
    logic [7:0]  rd;
    bit          differ;
    if (rst) begin
      for (int j = 0; j <= D; j++) hist[j] = '0;
      m_stable = '0;
      m_latch  = '0;
      m_rdata  = '0;
      m_rvalid = 1'b0;
    end else begin
      nxt = m_stable;
      for (int b = 0; b < 21; b++) begin
        differ = 1'b1;
        for (int j = 1; j <= D; j++) begin
          if (hist[j][b] == m_stable[b]) differ = 1'b0;
        end
        if (differ) nxt[b] = ~m_stable[b];
      end
      rise = nxt[20:16] & ~m_stable[20:16];
      if (read_enable) begin
        if (read_address == 8'h00)      rd = m_stable[7:0];
        else if (read_address == 8'h01) rd = m_stable[15:8];
        else if (read_address == 8'h02) rd = {3'b000, m_stable[20:16]};
        else if (read_address == 8'h03) rd = {3'b000, m_latch};
        else if (read_address == 8'h04) rd = 8'hB3;
        else                            rd = 8'h00;
        m_rdata = rd;
        if (read_address == 8'h03) m_latch = '0;
      end
      m_rvalid = read_enable;
      m_latch  = m_latch | rise;
      m_stable = nxt;
      for (int j = D; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = {btn, sw};
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic re, input logic [7:0] addr);
    read_enable  = re;
    read_address = addr;
  endtask

  // Advance to the next falling edge and compare all outputs against the model.
  task automatic step();
    @(negedge clk);
    if (check_en) begin
      checkOutput("model read_valid", 8'(read_valid), 8'(m_rvalid));
      checkOutput("model read_data", read_data, m_rdata);
      checkOutput("model btn_irq", 8'(btn_irq), 8'(|m_latch));
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input logic [4:0] mask);
    btn = mask;
    steps(8);
    btn = 5'h00;
    steps(8);
  endtask

  task automatic read_one(input string name, input logic [7:0] addr, input logic [7:0] exp);
    applyStimulus(1'b1, addr);
    step();
    checkOutput(name, read_data, exp);
    checkOutput("read_valid", 8'(read_valid), 8'h01);
    applyStimulus(1'b0, 8'h00);
  endtask

  initial begin
    bit irq_seen;
    tests_run    = 0;
    tests_failed = 0;
    check_en     = 1'b0;

    vecs[0] = '{8'h03, 8'h1F, 1'b0};
    vecs[1] = '{8'h03, 8'h00, 1'b0};
    vecs[2] = '{8'h00, 8'h5A, 1'b0};
    vecs[3] = '{8'h01, 8'hA5, 1'b0};
    vecs[4] = '{8'h7F, 8'h00, 1'b0};
    vecs[5] = '{8'h02, 8'h00, 1'b0};
    vecs[6] = '{8'h05, 8'h00, 1'b0};
    vecs[7] = '{8'hFF, 8'h00, 1'b0};
    vecs[8] = '{8'h04, 8'hB3, 1'b0};

    // Reset with every input already high.
    rst = 1'b1;
    sw  = 16'hFFFF;
    btn = 5'h1F;
    applyStimulus(1'b0, 8'h00);
    step();
    checkOutput("reset read_data", read_data, 8'h00);
    checkOutput("reset read_valid", 8'(read_valid), 8'h00);
    checkOutput("reset btn_irq", 8'(btn_irq), 8'h00);
    check_en = 1'b1;
    step();
    rst = 1'b0;
    steps(6);
    applyStimulus(1'b1, 8'h00);
    step();
    checkOutput("post-reset sw lo", read_data, 8'hFF);
    applyStimulus(1'b1, 8'h01);
    step();
    checkOutput("post-reset sw hi", read_data, 8'hFF);
    applyStimulus(1'b1, 8'h02);
    step();
    checkOutput("post-reset btn", read_data, 8'h1F);
    applyStimulus(1'b0, 8'h00);

    // Switch pattern plus the full register map, read back-to-back.
    sw  = 16'hA55A;
    btn = 5'h00;
    steps(10);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, vecs[i].addr);
      step();
      checkOutput("table read_data", read_data, vecs[i].exp_data);
      checkOutput("table read_valid", 8'(read_valid), 8'h01);
      checkOutput("table btn_irq", 8'(btn_irq), 8'(vecs[i].exp_irq));
    end
    applyStimulus(1'b0, 8'h00);
    step();
    checkOutput("idle read_valid", 8'(read_valid), 8'h00);
    checkOutput("idle read_data hold", read_data, 8'hB3);

    // Short glitch must be rejected.
    btn = 5'h01;
    steps(3);
    btn = 5'h00;
    irq_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (btn_irq !== 1'b0) irq_seen = 1'b1;
    end
    checkOutput("glitch irq never rose", 8'(irq_seen), 8'h00);
    read_one("glitch btn_stable", 8'h02, 8'h00);
    read_one("glitch latch", 8'h03, 8'h00);

    // A held press lands exactly 2 + D edges after the raw rise.
    btn = 5'h01;
    steps(5);
    checkOutput("press edge 5 irq", 8'(btn_irq), 8'h00);
    step();
    checkOutput("press edge 6 irq", 8'(btn_irq), 8'h01);
    steps(4);
    btn = 5'h00;
    steps(8);
    read_one("held press latch", 8'h03, 8'h01);

    // Two presses accumulate, then clear-on-read.
    press(5'h04);
    press(5'h10);
    checkOutput("two presses irq", 8'(btn_irq), 8'h01);
    applyStimulus(1'b1, 8'h03);
    step();
    checkOutput("clear read 1", read_data, 8'h14);
    checkOutput("irq after clear", 8'(btn_irq), 8'h00);
    step();
    checkOutput("clear read 2", read_data, 8'h00);
    applyStimulus(1'b0, 8'h00);

    // New press coinciding with a clearing read.
    press(5'h01);
    btn = 5'h02;
    steps(5);
    applyStimulus(1'b1, 8'h03);
    step();
    checkOutput("set-wins read", read_data, 8'h01);
    checkOutput("set-wins irq", 8'(btn_irq), 8'h01);
    step();
    checkOutput("set-wins latch", read_data, 8'h02);
    applyStimulus(1'b0, 8'h00);
    btn = 5'h00;
    steps(8);

    // Reset overrides a pending clearing read.
    press(5'h04);
    checkOutput("pre-reset irq", 8'(btn_irq), 8'h01);
    rst = 1'b1;
    applyStimulus(1'b1, 8'h03);
    step();
    checkOutput("mid-read reset valid", 8'(read_valid), 8'h00);
    checkOutput("mid-read reset data", read_data, 8'h00);
    checkOutput("mid-read reset irq", 8'(btn_irq), 8'h00);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00);
    steps(2);
    read_one("latch after reset", 8'h03, 8'h00);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) btn = 5'($urandom);
      if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
      if ($urandom_range(0, 3) == 0) read_address = 8'($urandom);
      else read_address = 8'($urandom_range(0, 5));
      read_enable = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00);
    steps(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
